// File: rtl/color_pkg.sv
// Shared hue types: sextant encoding and the step to the next sextant.
// The sextant names read as <full channel>_<ramping channel><direction>.
package color_pkg;

    localparam int SEXTANT_COUNT = 6;

    typedef enum logic [2:0] {
        SX_R_GUP = 3'd0,
        SX_G_RDN = 3'd1,
        SX_G_BUP = 3'd2,
        SX_B_GDN = 3'd3,
        SX_B_RUP = 3'd4,
        SX_R_BDN = 3'd5
    } sextant_t;

    function automatic sextant_t next_sextant(input sextant_t s);
        if (s == SX_R_BDN) begin
            return SX_R_GUP;
        end
        return sextant_t'(s + 3'd1);
    endfunction

endpackage

// File: rtl/period_timer.sv
// PWM period timer: counts cycles within one period and flags its
// first cycle (period_start) and its last enabled cycle (period_end).
module period_timer #(
    parameter int PWM_INTERVAL = 1200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic period_start,
    output logic period_end
);

    localparam int CW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
    localparam logic [CW-1:0] LAST = CW'(PWM_INTERVAL - 1);

    logic [CW-1:0] cyc_cnt;

    assign period_start = rst_n && en && (cyc_cnt == '0);
    assign period_end   = rst_n && en && (cyc_cnt == LAST);

    // Cycle counter: advances only when enabled, wraps at the period end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
        end else if (en) begin
            cyc_cnt <= (cyc_cnt == LAST) ? '0 : cyc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hue_sequencer.sv
// Hue wheel sequencer: ramps one RGB channel per sextant in fixed duty
// steps, updating duties only at PWM period boundaries.
module hue_sequencer
    import color_pkg::*;
#(
    parameter  int PWM_INTERVAL = 1200,
    parameter  int RAMP_STEPS   = 100,
    parameter  int STEP_PERIODS = 20,
    localparam int DW           = $clog2(PWM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [DW-1:0] duty_r,
    output logic [DW-1:0] duty_g,
    output logic [DW-1:0] duty_b,
    output logic          period_start,
    output logic [2:0]    sextant
);

    localparam int DUTY_STEP = PWM_INTERVAL / RAMP_STEPS;
    localparam int PW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int SW = (RAMP_STEPS > 1) ? $clog2(RAMP_STEPS) : 1;
    localparam logic [DW-1:0] STEP = DW'(DUTY_STEP);
    localparam logic [DW-1:0] FULL = DW'(PWM_INTERVAL);
    localparam logic [PW-1:0] PER_LAST = PW'(STEP_PERIODS - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(RAMP_STEPS - 1);

    if (PWM_INTERVAL % RAMP_STEPS != 0) begin : g_bad_step
        $error("PWM_INTERVAL must be an exact multiple of RAMP_STEPS");
    end

    logic          period_end;
    logic          step_evt;
    logic          sext_wrap;
    logic [PW-1:0] per_cnt;
    logic [SW-1:0] step_cnt;
    sextant_t      state;
    sextant_t      state_n;
    logic [DW-1:0] r_n;
    logic [DW-1:0] g_n;
    logic [DW-1:0] b_n;

    period_timer #(
        .PWM_INTERVAL(PWM_INTERVAL)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .period_start(period_start),
        .period_end  (period_end)
    );

    assign step_evt  = period_end && (per_cnt == PER_LAST);
    assign sext_wrap = step_evt && (step_cnt == STEP_LAST);
    assign sextant   = state;

    // Period and step counters, sextant state and duty registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_cnt  <= '0;
            step_cnt <= '0;
            state    <= SX_R_GUP;
            duty_r   <= FULL;
            duty_g   <= '0;
            duty_b   <= '0;
        end else begin
            if (period_end) begin
                per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;
            end
            if (step_evt) begin
                step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
            end
            state  <= state_n;
            duty_r <= r_n;
            duty_g <= g_n;
            duty_b <= b_n;
        end
    end

    // Ramp the active channel on each step; advance sextant at its end.
    always_comb begin
        state_n = state;
        r_n     = duty_r;
        g_n     = duty_g;
        b_n     = duty_b;
        if (step_evt) begin
            unique case (state)
                SX_R_GUP: g_n = duty_g + STEP;
                SX_G_RDN: r_n = duty_r - STEP;
                SX_G_BUP: b_n = duty_b + STEP;
                SX_B_GDN: g_n = duty_g - STEP;
                SX_B_RUP: r_n = duty_r + STEP;
                SX_R_BDN: b_n = duty_b - STEP;
                default:  state_n = SX_R_GUP;
            endcase
            if (sext_wrap) begin
                state_n = next_sextant(state);
            end
        end
    end

endmodule

// File: tb/tb_hue_sequencer.sv
// Directed bench for hue_sequencer with PWM_INTERVAL=8, RAMP_STEPS=4,
// STEP_PERIODS=2: step every 16 cycles, sextant every 64.
module tb_hue_sequencer;

    localparam int PI = 8;
    localparam int RS = 4;
    localparam int SP = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] duty_r;
    logic [3:0] duty_g;
    logic [3:0] duty_b;
    logic       period_start;
    logic [2:0] sextant;

    int         vectors = 0;
    int         miscompares = 0;
    logic       inv_on = 1'b0;
    logic       prev_valid = 1'b0;
    logic [3:0] pr;
    logic [3:0] pg;
    logic [3:0] pb;

    always #5 clk = ~clk;

    hue_sequencer #(
        .PWM_INTERVAL(PI),
        .RAMP_STEPS  (RS),
        .STEP_PERIODS(SP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .duty_r      (duty_r),
        .duty_g      (duty_g),
        .duty_b      (duty_b),
        .period_start(period_start),
        .sextant     (sextant)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample the current cycle and apply the always-on checks.
    task automatic half();
        int nfull;
        int nzero;
        logic ok;
        @(negedge clk);
        if (inv_on) begin
            nfull = int'(duty_r == 4'(PI)) + int'(duty_g == 4'(PI))
                  + int'(duty_b == 4'(PI));
            nzero = int'(duty_r == 4'd0) + int'(duty_g == 4'd0)
                  + int'(duty_b == 4'd0);
            ok = (nfull >= 1) && (nzero >= 1) && (duty_r <= 4'(PI))
              && (duty_g <= 4'(PI)) && (duty_b <= 4'(PI));
            chk("invariant", 32'(ok), 32'd1);
            if (prev_valid && rst_n
                && ({duty_r, duty_g, duty_b} !== {pr, pg, pb})) begin
                chk("duty_change_ps", 32'(period_start), 32'd1);
            end
            pr = duty_r;
            pg = duty_g;
            pb = duty_b;
            prev_valid = 1'b1;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ec;
        int t;
        rst_n = 1'b0;
        en    = 1'b1;
        adv();
        inv_on = 1'b1;

        repeat (3) begin
            half();
            chk("rst_r", 32'(duty_r), 32'd8);
            chk("rst_g", 32'(duty_g), 32'd0);
            chk("rst_b", 32'(duty_b), 32'd0);
            chk("rst_sext", 32'(sextant), 32'd0);
            chk("rst_ps", 32'(period_start), 32'd0);
            adv();
        end
        rst_n = 1'b1;

        for (int c = 0; c <= 768; c++) begin
            half();
            chk("ps_free", 32'(period_start), 32'(c % 8 == 0));
            chk("sext_seq", 32'(sextant), 32'((c / 64) % 6));
            if (c == 16) chk("g_at16", 32'(duty_g), 32'd2);
            if (c == 63) chk("g_at63", 32'(duty_g), 32'd6);
            if (c == 64) begin
                chk("g_at64", 32'(duty_g), 32'd8);
                chk("r_at64", 32'(duty_r), 32'd8);
            end
            if (c == 80) chk("r_at80", 32'(duty_r), 32'd6);
            if (c == 384 || c == 768) begin
                chk("wrap_r", 32'(duty_r), 32'd8);
                chk("wrap_g", 32'(duty_g), 32'd0);
                chk("wrap_b", 32'(duty_b), 32'd0);
            end
            adv();
        end

        rst_n = 1'b0;
        half();
        chk("rst2_ps", 32'(period_start), 32'd0);
        adv();
        rst_n = 1'b1;

        for (int a = 0; a <= 100; a++) begin
            en = !(a >= 40 && a < 60);
            ec = (a < 40) ? a : ((a < 60) ? 40 : a - 20);
            half();
            chk("ps_pause", 32'(period_start), 32'(en && (ec % 8 == 0)));
            if (!en) begin
                chk("frz_r", 32'(duty_r), 32'd8);
                chk("frz_g", 32'(duty_g), 32'd4);
                chk("frz_b", 32'(duty_b), 32'd0);
                chk("frz_sext", 32'(sextant), 32'd0);
            end
            if (a == 67) chk("g_at67", 32'(duty_g), 32'd4);
            if (a == 68) chk("g_at68", 32'(duty_g), 32'd6);
            adv();
        end
        en = 1'b1;

        rst_n = 1'b0;
        half();
        adv();
        rst_n = 1'b1;

        for (int a = 0; a <= 300; a++) begin
            rst_n = (a != 200);
            half();
            if (a <= 200) chk("sext_pre", 32'(sextant), 32'((a / 64) % 6));
            if (a == 200) chk("ps_in_rst", 32'(period_start), 32'd0);
            if (a >= 201) begin
                t = a - 201;
                chk("ps_restart", 32'(period_start), 32'(t % 8 == 0));
                chk("sext_restart", 32'(sextant), 32'((t / 64) % 6));
                if (t == 0) begin
                    chk("rs_r", 32'(duty_r), 32'd8);
                    chk("rs_g", 32'(duty_g), 32'd0);
                    chk("rs_b", 32'(duty_b), 32'd0);
                end
                if (t == 16) chk("rs_g16", 32'(duty_g), 32'd2);
                if (t == 64) chk("rs_g64", 32'(duty_g), 32'd8);
                if (t == 80) chk("rs_r80", 32'(duty_r), 32'd6);
            end
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
